ldm_stm_sequencer: RTL and testbench

//  Multi-cycle sequencer for ARM32 LDM/STM block transfers. Walks a 16-bit register list and drives the register-file

---
 rtl/arm32_pkg.sv | 13 +
 rtl/reg_list_scan.sv | 31 +++
 rtl/ldm_stm_sequencer.sv | 169 ++++++++++++++++
 tb/tb_ldm_stm_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/arm32_pkg.sv
// Shared types and constants for the ARM32 block-transfer datapath.
package arm32_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        XFER   = 2'd1,
        FINISH = 2'd2
    } ldm_state_t;

    localparam logic [3:0] REG_PC     = 4'd15;
    localparam int         WORD_BYTES = 4;

endpackage

// File: rtl/reg_list_scan.sv
// Combinational register-list scanner: index of the lowest set bit plus population count.
module reg_list_scan #(
    parameter int NREGS = 16
) (
    input  logic [NREGS-1:0]             list,
    output logic [$clog2(NREGS)-1:0]     low_idx,
    output logic                         low_valid,
    output logic [$clog2(NREGS+1)-1:0]   count
);

    localparam int IDX_W = $clog2(NREGS);
    localparam int CNT_W = $clog2(NREGS + 1);

    // NOTE: every output gets a default before the loops, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        low_idx   = '0;
        low_valid = 1'b0;
        count     = '0;
        // Scanning downward lets the last hit be the lowest set bit.
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (list[i]) begin
                low_idx   = IDX_W'(i);
                low_valid = 1'b1;
            end
        end
        for (int i = 0; i < NREGS; i++) begin
            count = count + CNT_W'(list[i]);
        end
    end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer: walks the register list, one register per accepted memory beat,
// and writes the final base back in the FINISH cycle.
module ldm_stm_sequencer
    import arm32_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       is_load,
    input  logic                       up,
    input  logic                       pre,
    input  logic                       wback,
    input  logic [$clog2(NREGS)-1:0]   base_reg,
    input  logic [DATA_W-1:0]          base_val,
    input  logic [NREGS-1:0]           reg_list,
    output logic                       busy,
    output logic                       done,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [DATA_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wd,
    input  logic [DATA_W-1:0]          mem_rd,
    input  logic                       mem_ready,
    output logic [$clog2(NREGS)-1:0]   rf_ra,
    input  logic [DATA_W-1:0]          rf_rd,
    output logic [$clog2(NREGS)-1:0]   rf_wa,
    output logic [DATA_W-1:0]          rf_wd,
    output logic                       rf_we,
    output logic                       pc_we,
    output logic [DATA_W-1:0]          pc_wd
);

    localparam int                IDX_W = $clog2(NREGS);
    localparam int                CNT_W = $clog2(NREGS + 1);
    localparam logic [DATA_W-1:0] WORD  = DATA_W'(WORD_BYTES);

    ldm_state_t          state_q, next_state;
    logic [NREGS-1:0]    list_q;
    logic [DATA_W-1:0]   addr_q;
    logic                load_q;
    logic                wb_en_q;
    logic [IDX_W-1:0]    wb_reg_q;
    logic [DATA_W-1:0]   wb_val_q;

    logic [NREGS-1:0]    scan_list;
    logic [IDX_W-1:0]    scan_idx;
    logic                scan_valid;
    logic [CNT_W-1:0]    scan_count;

    logic                launch;
    logic                beat_done;
    logic [DATA_W-1:0]   span;
    logic [DATA_W-1:0]   start_addr;

    // One scanner serves both the launch popcount (IDLE) and the per-beat register pick (XFER).
    assign scan_list = (state_q == IDLE) ? reg_list : list_q;

    reg_list_scan #(.NREGS(NREGS)) u_scan (
        .list      (scan_list),
        .low_idx   (scan_idx),
        .low_valid (scan_valid),
        .count     (scan_count)
    );

    assign launch    = (state_q == IDLE) && start;
    assign beat_done = (state_q == XFER) && scan_valid && mem_ready;
    assign span      = DATA_W'(scan_count) << $clog2(WORD_BYTES);

    always_comb begin
        unique case ({up, pre})
            2'b10:   start_addr = base_val;
            2'b11:   start_addr = base_val + WORD;
            2'b00:   start_addr = base_val - span + WORD;
            default: start_addr = base_val - span;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            list_q   <= '0;
            addr_q   <= '0;
            load_q   <= 1'b0;
            wb_en_q  <= 1'b0;
            wb_reg_q <= '0;
            wb_val_q <= '0;
        end else begin
            state_q <= next_state;
            if (launch) begin
                list_q   <= reg_list;
                addr_q   <= start_addr;
                load_q   <= is_load;
                wb_reg_q <= base_reg;
                wb_val_q <= up ? (base_val + span) : (base_val - span);
                // A loaded Rn must not be overwritten by the final base value.
                wb_en_q  <= wback && (base_reg != IDX_W'(REG_PC)) && (reg_list != '0)
                            && !(is_load && reg_list[base_reg]);
            end
            if (beat_done) begin
                list_q[scan_idx] <= 1'b0;
                addr_q           <= addr_q + WORD;
            end
        end
    end

    always_comb begin
        next_state = state_q;
        busy       = 1'b0;
        done       = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wd     = '0;
        rf_ra      = '0;
        rf_wa      = '0;
        rf_wd      = '0;
        rf_we      = 1'b0;
        pc_we      = 1'b0;
        pc_wd      = '0;

        unique case (state_q)
            IDLE: begin
                // An empty list still passes through XFER so done lands two cycles after start.
                if (start) next_state = XFER;
            end

            XFER: begin
                busy = 1'b1;
                if (!scan_valid) begin
                    next_state = FINISH;
                end else begin
                    mem_req  = 1'b1;
                    mem_addr = addr_q;
                    mem_we   = !load_q;
                    if (!load_q) begin
                        rf_ra  = scan_idx;
                        mem_wd = rf_rd;
                    end else if (mem_ready) begin
                        if (scan_idx == IDX_W'(REG_PC)) begin
                            pc_we = 1'b1;
                            pc_wd = mem_rd;
                        end else begin
                            rf_we = 1'b1;
                            rf_wa = scan_idx;
                            rf_wd = mem_rd;
                        end
                    end
                    if (mem_ready && (scan_count == CNT_W'(1))) next_state = FINISH;
                end
            end

            FINISH: begin
                busy       = 1'b1;
                done       = 1'b1;
                rf_we      = wb_en_q;
                rf_wa      = wb_en_q ? wb_reg_q : '0;
                rf_wd      = wb_en_q ? wb_val_q : '0;
                next_state = IDLE;
            end

            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer: table of block transfers with hand-computed addresses,
// writeback values and done cycles, plus reset-abort and start-while-busy sequences.
module tb_ldm_stm_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, is_load, up, pre, wback;
    logic [3:0]  base_reg;
    logic [31:0] base_val;
    logic [15:0] reg_list;
    logic        busy, done, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic        mem_ready;
    logic [3:0]  rf_ra, rf_wa;
    logic [31:0] rf_rd, rf_wd;
    logic        rf_we, pc_we;
    logic [31:0] pc_wd;

    localparam logic [31:0] MEM_KEY = 32'h5A5A_5A5A;

    always #5 clk = ~clk;

    // Memory returns a word derived from its address; the register file returns CAFE000x for Rx.
    assign mem_rd = mem_addr ^ MEM_KEY;
    assign rf_rd  = {16'hCAFE, 12'h000, rf_ra};

    ldm_stm_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .is_load(is_load), .up(up), .pre(pre),
        .wback(wback), .base_reg(base_reg), .base_val(base_val), .reg_list(reg_list),
        .busy(busy), .done(done), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wd(mem_wd), .mem_rd(mem_rd), .mem_ready(mem_ready), .rf_ra(rf_ra), .rf_rd(rf_rd),
        .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_we(rf_we), .pc_we(pc_we), .pc_wd(pc_wd)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_load;
        logic        up;
        logic        pre;
        logic        wback;
        logic [3:0]  base_reg;
        logic [31:0] base_val;
        logic [15:0] reg_list;
        int          waits;
        bit          poke;
        logic [31:0] exp_start;
        logic        exp_wb;
        logic [31:0] exp_wb_val;
        int          exp_done;
    } vec_t;

    vec_t vecs[10];

    task automatic check_idle(input string tag);
        check({tag, " busy"},    32'(busy),    32'd0);
        check({tag, " done"},    32'(done),    32'd0);
        check({tag, " mem_req"}, 32'(mem_req), 32'd0);
        check({tag, " rf_we"},   32'(rf_we),   32'd0);
        check({tag, " pc_we"},   32'(pc_we),   32'd0);
        check({tag, " addr"},    mem_addr,     32'd0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [15:0] rem;
        logic [3:0]  exp_reg;
        logic [31:0] exp_addr;
        int k, stall, cyc;
        bit finished;
        rem = v.reg_list; k = 0; stall = 0; cyc = 0; finished = 0;

        @(negedge clk);
        is_load = v.is_load; up = v.up; pre = v.pre; wback = v.wback;
        base_reg = v.base_reg; base_val = v.base_val; reg_list = v.reg_list;
        mem_ready = 1'b0; start = 1'b1;
        @(posedge clk);

        while (!finished && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (v.poke && cyc == 2) begin
                start = 1'b1; reg_list = 16'hFFFF; base_val = 32'hDEAD_0000; is_load = ~v.is_load;
            end
            exp_reg = 4'd0;
            for (int i = 15; i >= 0; i--) if (rem[i]) exp_reg = 4'(i);
            exp_addr = v.exp_start + 32'(4 * k);

            if (rem != 16'h0000) begin
                mem_ready = (stall >= v.waits);
                #1;
                check({tag, " mem_req"}, 32'(mem_req), 32'd1);
                check({tag, " addr"},    mem_addr,     exp_addr);
                check({tag, " mem_we"},  32'(mem_we),  32'(!v.is_load));
                check({tag, " done"},    32'(done),    32'd0);
                if (!v.is_load) begin
                    check({tag, " rf_ra"},  32'(rf_ra), 32'(exp_reg));
                    check({tag, " mem_wd"}, mem_wd,     {16'hCAFE, 12'h000, exp_reg});
                end
                if (mem_ready && v.is_load && exp_reg == 4'd15) begin
                    check({tag, " pc_we"}, 32'(pc_we), 32'd1);
                    check({tag, " pc_wd"}, pc_wd,      exp_addr ^ MEM_KEY);
                    check({tag, " rf_we"}, 32'(rf_we), 32'd0);
                end else if (mem_ready && v.is_load) begin
                    check({tag, " rf_we"}, 32'(rf_we), 32'd1);
                    check({tag, " rf_wa"}, 32'(rf_wa), 32'(exp_reg));
                    check({tag, " rf_wd"}, rf_wd,      exp_addr ^ MEM_KEY);
                    check({tag, " pc_we"}, 32'(pc_we), 32'd0);
                end else begin
                    check({tag, " rf_we"}, 32'(rf_we), 32'd0);
                    check({tag, " pc_we"}, 32'(pc_we), 32'd0);
                end
                if (mem_ready) begin
                    rem[exp_reg] = 1'b0; k++; stall = 0;
                end else begin
                    stall++;
                end
            end else begin
                mem_ready = 1'b0;
                #1;
                check({tag, " mem_req"}, 32'(mem_req), 32'd0);
                check({tag, " pc_we"},   32'(pc_we),   32'd0);
                if (done) begin
                    finished = 1;
                    check({tag, " done cycle"}, 32'(cyc), 32'(v.exp_done));
                    check({tag, " wb rf_we"},   32'(rf_we), 32'(v.exp_wb));
                    if (v.exp_wb) begin
                        check({tag, " wb rf_wa"}, 32'(rf_wa), 32'(v.base_reg));
                        check({tag, " wb rf_wd"}, rf_wd,      v.exp_wb_val);
                    end
                end else begin
                    check({tag, " rf_we"}, 32'(rf_we), 32'd0);
                end
            end
            check({tag, " busy"}, 32'(busy), 32'd1);
        end
        if (!finished) check({tag, " done timeout"}, 32'(cyc), 32'(v.exp_done));

        @(negedge clk);
        #1;
        check({tag, " busy after"}, 32'(busy), 32'd0);
        check({tag, " done after"}, 32'(done), 32'd0);
    endtask

    initial begin
        // Columns: load up pre wb Rn base list waits poke | start_addr wb wb_val done_cycle
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd4,  32'h0000_0100, 16'h000E, 0, 1'b0, 32'h0000_0100, 1'b1, 32'h0000_010C, 4};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 32'h0000_0200, 16'h4003, 0, 1'b0, 32'h0000_01F4, 1'b1, 32'h0000_01F4, 4};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd5,  32'h0000_0300, 16'h8001, 2, 1'b1, 32'h0000_0304, 1'b0, 32'h0000_0000, 7};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd2,  32'h0000_0400, 16'h0004, 0, 1'b0, 32'h0000_0400, 1'b0, 32'h0000_0000, 2};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd3,  32'h0000_0500, 16'h0000, 0, 1'b0, 32'h0000_0500, 1'b0, 32'h0000_0000, 2};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd6,  32'h0000_0000, 16'h0007, 0, 1'b0, 32'hFFFF_FFF8, 1'b1, 32'hFFFF_FFF4, 4};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd15, 32'h0000_0600, 16'h0010, 0, 1'b0, 32'h0000_0600, 1'b0, 32'h0000_0000, 2};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd9,  32'h0000_0700, 16'h00FF, 1, 1'b0, 32'h0000_06E0, 1'b1, 32'h0000_06E0, 17};
        vecs[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd0,  32'hFFFF_FFF8, 16'h8000, 0, 1'b0, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 2};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd0,  32'h0000_1000, 16'h0300, 0, 1'b0, 32'h0000_0FFC, 1'b1, 32'h0000_0FF8, 3};

        reset = 1'b1; start = 1'b0; is_load = 1'b0; up = 1'b0; pre = 1'b0; wback = 1'b0;
        base_reg = 4'd0; base_val = 32'd0; reg_list = 16'd0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_idle("reset");
        reset = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Abort mid-transfer: reset must silence every strobe in the same cycle.
        @(negedge clk);
        is_load = 1'b1; up = 1'b1; pre = 1'b0; wback = 1'b1; base_reg = 4'd1;
        base_val = 32'h0000_0900; reg_list = 16'h00F0; mem_ready = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; mem_ready = 1'b1;
        #1;
        check("abort pre rf_we", 32'(rf_we), 32'd1);
        check("abort pre rf_wa", 32'(rf_wa), 32'd4);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_idle("abort");
        @(negedge clk);
        #1;
        check_idle("abort held");
        reset = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        #1;
        check_idle("abort released");

        run_vec(vecs[0], "post-reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
